// File: rtl/iter_shift_unit_if.sv
// Operand/result bundle between the issuing ALU front end and the iterative shift unit.
// The master drives the request; the slave returns the result, ready pulse and busy.
interface iter_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic [WIDTH-1:0]   data_operandA;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [1:0]         ctrl_shiftop;
    logic               ctrl_start;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output data_operandA, ctrl_shiftamt, ctrl_shiftop, ctrl_start,
        input  data_result, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, ctrl_shiftamt, ctrl_shiftop, ctrl_start,
        output data_result, data_resultRDY, busy
    );
endinterface

// File: rtl/iter_shift_unit.sv
// Iterative SLL/SRL/SRA unit: one single-bit shift per clock, result handed to
// writeback with a one-cycle ready pulse taken straight from the DONE state.
//
// state | meaning
// IDLE  | waiting for a start request
// SHIFT | applying one shift per clock, counter counts down to the last step
// DONE  | result valid, ready pulse high; a new start may be accepted here
module iter_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    iter_shift_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b10;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   acc_shifted;
    logic               accept;
    logic               last_step;

    // Reserved op code 11 falls into the arithmetic-right default.
    always_comb begin
        acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        case (op_q)
            OP_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
            OP_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
            default: acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        endcase
    end

    assign last_step = (state_q == SHIFT) && (cnt_q == SHAMT_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ctrl_start) begin
                    accept = 1'b1;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.ctrl_start) begin
                    accept = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A zero shift distance skips SHIFT so the counter can never wrap.
        if (accept) begin
            state_d = (bus.ctrl_shiftamt == '0) ? DONE : SHIFT;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else if (accept) begin
            acc_q <= bus.data_operandA;
            cnt_q <= bus.ctrl_shiftamt;
            op_q  <= bus.ctrl_shiftop;
            if (bus.ctrl_shiftamt == '0) begin
                result_q <= bus.data_operandA;
            end
        end else if (state_q == SHIFT) begin
            acc_q <= acc_shifted;
            cnt_q <= cnt_q - SHAMT_W'(1);
            if (last_step) begin
                result_q <= acc_shifted;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_resultRDY = (state_q == DONE);
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed bench for iter_shift_unit: hand-computed results, ready/busy timing per edge,
// ignored mid-shift start, asynchronous reset mid-operation and back-to-back issue.
module tb_iter_shift_unit;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;

    iter_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; E0 is the next posedge. Checks the samples taken just
    // before E1..E_{n+2} and returns at a negedge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input int n, input logic [31:0] exp);
        bus.ctrl_shiftop  = op;
        bus.data_operandA = a;
        bus.ctrl_shiftamt = 5'(n);
        bus.ctrl_start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_start = 1'b0;
        for (int k = 1; k <= n + 2; k++) begin
            check_val({tag, "_busy"}, 32'(bus.busy), 32'(k <= n + 1));
            check_val({tag, "_rdy"}, 32'(bus.data_resultRDY), 32'(k == n + 1));
            if (k == n + 1) check_val({tag, "_res"}, bus.data_result, exp);
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.ctrl_start    = 1'b0;
        bus.ctrl_shiftop  = 2'b00;
        bus.data_operandA = '0;
        bus.ctrl_shiftamt = '0;
        repeat (2) @(negedge clock);
        check_val("rst_res", bus.data_result, 32'h0);
        check_val("rst_rdy", 32'(bus.data_resultRDY), 32'h0);
        check_val("rst_busy", 32'(bus.busy), 32'h0);
        reset = 1'b1;
        @(negedge clock);

        run_op("sra4",   2'b01, 32'h8000_0000, 4,  32'hF800_0000);
        run_op("sll31",  2'b00, 32'h0000_0001, 31, 32'h8000_0000);
        run_op("srl28",  2'b10, 32'hF000_0000, 28, 32'h0000_000F);
        run_op("n0_sll", 2'b00, 32'h1234_5678, 0,  32'h1234_5678);
        run_op("n0_sra", 2'b01, 32'h1234_5678, 0,  32'h1234_5678);
        run_op("op11",   2'b11, 32'h8000_0010, 1,  32'hC000_0008);

        // Start pulsed at E3 during an 8-step SRA must be ignored.
        bus.ctrl_shiftop  = 2'b01;
        bus.data_operandA = 32'hFFFF_0000;
        bus.ctrl_shiftamt = 5'd8;
        bus.ctrl_start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            check_val("ign_busy", 32'(bus.busy), 32'(k <= 9));
            check_val("ign_rdy", 32'(bus.data_resultRDY), 32'(k == 9));
            if (k == 9 || k == 11) check_val("ign_res", bus.data_result, 32'hFFFF_FF00);
            if (k == 3) begin
                bus.ctrl_shiftop  = 2'b00;
                bus.data_operandA = 32'h0000_0001;
                bus.ctrl_shiftamt = 5'd2;
                bus.ctrl_start    = 1'b1;
            end else begin
                bus.ctrl_start = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
        end

        // Asynchronous reset dropped between E4 and E5 of a 10-step SLL.
        bus.ctrl_shiftop  = 2'b00;
        bus.data_operandA = 32'h0000_0003;
        bus.ctrl_shiftamt = 5'd10;
        bus.ctrl_start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_start = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        check_val("pre_rst_busy", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #1;
        check_val("arst_res", bus.data_result, 32'h0);
        check_val("arst_rdy", 32'(bus.data_resultRDY), 32'h0);
        check_val("arst_busy", 32'(bus.busy), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_val("post_rst_busy", 32'(bus.busy), 32'h0);
        run_op("after_rst", 2'b00, 32'h0000_0003, 1, 32'h0000_0006);

        // Back-to-back: second request accepted at the edge that ends the first DONE.
        bus.ctrl_shiftop  = 2'b10;
        bus.data_operandA = 32'h0000_0100;
        bus.ctrl_shiftamt = 5'd2;
        bus.ctrl_start    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            check_val("b2b_busy", 32'(bus.busy), 32'(k <= 8));
            check_val("b2b_rdy", 32'(bus.data_resultRDY), 32'(k == 3 || k == 8));
            if (k == 3) check_val("b2b_res1", bus.data_result, 32'h0000_0040);
            if (k == 8) check_val("b2b_res2", bus.data_result, 32'h0000_0010);
            if (k == 3) begin
                bus.data_operandA = 32'h0000_0100;
                bus.ctrl_shiftamt = 5'd4;
                bus.ctrl_start    = 1'b1;
            end else begin
                bus.ctrl_start = 1'b0;
            end
            @(posedge clock);
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
